// File: rtl/seq_shifter_pkg.sv
// seq_shifter_pkg: op-code encodings and FSM state type shared by the
// seq_shifter top and its shift_step datapath slice.
package seq_shifter_pkg;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_ROTR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : seq_shifter_pkg

// File: rtl/seq_shifter_step.sv
// shift_step: combinational shift of din by k (0..STEP) according to op.
// SRA fills with the supplied fill bit.
// Rotate support is built only when SEQ_SHIFTER_ROTR_EN is defined;
// otherwise op 100 falls into the passthrough arm.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned KW    = $clog2(STEP + 1)
) (
  input  logic [2:0]       op,
  input  logic             fill,
  input  logic [KW-1:0]    k,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] fill_mask;

  // Select the shifted value for the current op; reserved codes pass through.
  always_comb begin
    ones      = '1;
    fill_mask = ~(ones >> k);
    dout      = din;
    case (op)
      OP_SLL,
      OP_LUI:  dout = din << k;
      OP_SRL:  dout = din >> k;
      OP_SRA:  dout = (din >> k) | (fill ? fill_mask : '0);
`ifdef SEQ_SHIFTER_ROTR_EN
      OP_ROTR: dout = (din >> k) | (din << (WIDTH - k));
`endif
      default: dout = din;
    endcase
  end

endmodule : shift_step

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle SLL/SRL/SRA/LUI shift unit, STEP bits per clock,
// with a start/busy/done handshake.
// Optional macro SEQ_SHIFTER_ROTR_EN enables op 100 as rotate-right.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 1,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam int unsigned        KW     = $clog2(STEP + 1);
  localparam logic [SHAMT_W-1:0] STEP_R = SHAMT_W'(STEP);
  localparam logic [SHAMT_W-1:0] LUI_R  = SHAMT_W'(WIDTH / 2);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic               fill_q, fill_d;

  logic [SHAMT_W-1:0] rem_load;
  logic [SHAMT_W-1:0] k_full;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   step_out;

  // Amount to shift on entry: shamt for real shifts, half-width for LUI, 0 otherwise.
  always_comb begin
    rem_load = '0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: rem_load = shamt;
      OP_LUI:                 rem_load = LUI_R;
`ifdef SEQ_SHIFTER_ROTR_EN
      OP_ROTR:                rem_load = shamt;
`endif
      default:                rem_load = '0;
    endcase
  end

  // Per-cycle shift amount k = min(STEP, rem); STEP <= WIDTH/2 so it fits in SHAMT_W.
  always_comb begin
    k_full = (rem_q < STEP_R) ? rem_q : STEP_R;
    k      = k_full[KW-1:0];
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .op   (op_q),
    .fill (fill_q),
    .k    (k),
    .din  (acc_q),
    .dout (step_out)
  );

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      op_q     <= op_d;
      fill_q   <= fill_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (rem_load != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (rem_q <= STEP_R) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture operands in IDLE, step acc/rem in SHIFT, publish result on entry to DONE.
  always_comb begin
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    op_d     = op_q;
    fill_d   = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d  = data_in;
          rem_d  = rem_load;
          op_d   = op;
          fill_d = data_in[WIDTH-1];
          if (rem_load == '0) result_d = data_in;
        end
      end
      ST_SHIFT: begin
        acc_d = step_out;
        rem_d = rem_q - k_full;
        if (rem_q <= STEP_R) result_d = step_out;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_DONE);
    result = result_q;
  end

endmodule : seq_shifter

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: drives a STEP=1 and a STEP=4 seq_shifter with shared
// stimulus and compares both against an arithmetic reference model.
module tb_seq_shifter;

  localparam int unsigned W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(W), .STEP(1), .SHAMT_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy1), .done(done1), .result(result1)
  );

  seq_shifter #(.WIDTH(W), .STEP(4), .SHAMT_W(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy4), .done(done4), .result(result4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int model_rem(input logic [2:0] o, input logic [4:0] sh);
    case (o)
      3'b000, 3'b001, 3'b010: return int'(sh);
      3'b011:                 return W / 2;
`ifdef SEQ_SHIFTER_ROTR_EN
      3'b100:                 return int'(sh);
`endif
      default:                return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] d,
                                            input logic [4:0] sh);
    logic [31:0] r;
    case (o)
      3'b000: return d << sh;
      3'b001: return d >> sh;
      3'b010: return $unsigned($signed(d) >>> sh);
      3'b011: return d << (W / 2);
`ifdef SEQ_SHIFTER_ROTR_EN
      3'b100: begin
        r = d;
        for (int i = 0; i < int'(sh); i++) r = {r[0], r[31:1]};
        return r;
      end
`endif
      default: return d;
    endcase
  endfunction

  function automatic int model_lat(input int rem, input int step);
    return (rem == 0) ? 1 : (rem + step - 1) / step + 1;
  endfunction

  // One transaction; poke > 0 pulses a spurious start in that cycle after acceptance.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] d,
                        input logic [4:0] sh, input int poke);
    logic [31:0] exp;
    int l1, l4, first1, first4, cnt1, cnt4;
    logic [31:0] res1, res4;
    exp = model_res(o, d, sh);
    l1  = model_lat(model_rem(o, sh), 1);
    l4  = model_lat(model_rem(o, sh), 4);
    first1 = 0; first4 = 0; cnt1 = 0; cnt4 = 0; res1 = '0; res4 = '0;
    @(negedge clk);
    start = 1'b1; op = o; data_in = d; shamt = sh;
    @(posedge clk);
    #1;
    start = 1'b0; data_in = ~d; shamt = ~sh;
    for (int i = 1; i <= l1 + 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk({nm, ".busy1_c1"}, 32'(busy1), 32'd1);
        chk({nm, ".busy4_c1"}, 32'(busy4), 32'd1);
      end
      if (done1) begin
        cnt1++;
        if (first1 == 0) begin first1 = i; res1 = result1; end
      end
      if (done4) begin
        cnt4++;
        if (first4 == 0) begin first4 = i; res4 = result4; end
      end
      if (i == poke) begin
        start = 1'b1; op = 3'($urandom_range(0, 7)); data_in = $urandom; shamt = 5'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, ".lat1"}, 32'(first1), 32'(l1));
    chk({nm, ".lat4"}, 32'(first4), 32'(l4));
    chk({nm, ".res1"}, res1, exp);
    chk({nm, ".res4"}, res4, exp);
    chk({nm, ".npulse1"}, 32'(cnt1), 32'd1);
    chk({nm, ".npulse4"}, 32'(cnt4), 32'd1);
    chk({nm, ".hold1"}, result1, exp);
    chk({nm, ".hold4"}, result4, exp);
    chk({nm, ".idle1"}, 32'(busy1), 32'd0);
    chk({nm, ".idle4"}, 32'(busy4), 32'd0);
  endtask

  initial begin
    int cnt;
    logic [2:0]  ro;
    logic [4:0]  rs;
    logic [31:0] rd;
    int pk;

    rst_n = 1'b0; start = 1'b0; op = '0; data_in = '0; shamt = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy1", 32'(busy1), 32'd0);
    chk("rst.done1", 32'(done1), 32'd0);
    chk("rst.res1", result1, 32'd0);
    chk("rst.busy4", 32'(busy4), 32'd0);
    chk("rst.res4", result4, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("sll31", 3'b000, 32'h0000_0001, 5'd31, 0);
    run_op("sra4",  3'b010, 32'h8000_0000, 5'd4, 2);
    run_op("srl4",  3'b001, 32'h8000_0000, 5'd4, 0);
    run_op("lui",   3'b011, 32'h0000_1234, 5'd7, 3);
    run_op("sll0",  3'b000, 32'hDEAD_BEEF, 5'd0, 1);
    run_op("rotr4", 3'b100, 32'h0000_00F1, 5'd4, 0);
    run_op("rsv7",  3'b111, 32'h1357_9BDF, 5'd9, 1);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; op = 3'b000; data_in = 32'h0000_0003; shamt = 5'd20;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy1", 32'(busy1), 32'd0);
    chk("abort.done1", 32'(done1), 32'd0);
    chk("abort.res1", result1, 32'd0);
    chk("abort.busy4", 32'(busy4), 32'd0);
    chk("abort.res4", result4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done1 || done4 || busy1 || busy4) cnt++;
    end
    chk("abort.quiet", 32'(cnt), 32'd0);
    chk("abort.res1_after", result1, 32'd0);

    for (int t = 0; t < 40; t++) begin
      ro = 3'($urandom_range(0, 7));
      rs = 5'($urandom);
      rd = $urandom;
      pk = (t % 3 == 0) ? 0 : $urandom_range(1, model_lat(model_rem(ro, rs), 4));
      run_op($sformatf("rnd%0d", t), ro, rd, rs, pk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_shifter
